lsu_req_arbiter: RTL

//  Merges the AGU-stage request streams of the two issue pipes into the single
//  LSU data-memory port.
//  - One holding slot per pipe.
//  - Oldest-first grant, so memory ops reach the LSU in program order.
//  - Misaligned requests are retired as exceptions instead of going to memory.
//  - Sits between the AGU stages and the LSU; flushed on pipeline redirect.

---
 rtl/lsu_req_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/lsu_req_arbiter.sv
// Two-slot request arbiter merging both AGU pipes onto the single LSU port.
// Grants oldest-first; misaligned requests retire as exceptions instead of going to memory.
module lsu_req_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned BE_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              a0_valid_i,
  output logic              a0_ready_o,
  input  logic              a0_store_i,
  input  logic [ADDR_W-1:0] a0_addr_i,
  input  logic [ADDR_W-1:0] a0_data_i,
  input  logic [BE_W-1:0]   a0_be_i,
  input  logic [RD_W-1:0]   a0_rd_i,
  input  logic              a0_misal_i,
  input  logic              a1_valid_i,
  output logic              a1_ready_o,
  input  logic              a1_store_i,
  input  logic [ADDR_W-1:0] a1_addr_i,
  input  logic [ADDR_W-1:0] a1_data_i,
  input  logic [BE_W-1:0]   a1_be_i,
  input  logic [RD_W-1:0]   a1_rd_i,
  input  logic              a1_misal_i,
  output logic              m_req_o,
  input  logic              m_ready_i,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [ADDR_W-1:0] m_wdata_o,
  output logic [BE_W-1:0]   m_be_o,
  output logic [RD_W-1:0]   m_rd_o,
  output logic              m_port_o,
  output logic              exc_valid_o,
  output logic [ADDR_W-1:0] exc_addr_o,
  output logic              exc_store_o,
  output logic              exc_port_o
);

  typedef struct packed {
    logic              store;
    logic              misal;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic [RD_W-1:0]   rd;
  } req_t;

  logic full0_q, full1_q, older_q;
  logic full0_d, full1_d, older_d;
  req_t slot0_q, slot1_q, slot0_d, slot1_d;

  logic kill_c, any_full_c, sel_c, drain_c, drain0_c, drain1_c;
  logic ready0_c, ready1_c, load0_c, load1_c, rem0_c, rem1_c;
  logic req_c, exc_c;
  req_t sel_req_c;

  // Selection, drain and slot next-state; reset behaves like a flush.
  always_comb begin
    kill_c     = flush_i | !rst_n;
    any_full_c = full0_q | full1_q;
    sel_c      = (full0_q & full1_q) ? older_q : full1_q;
    sel_req_c  = sel_c ? slot1_q : slot0_q;
    exc_c      = any_full_c & sel_req_c.misal & !kill_c;
    req_c      = any_full_c & !sel_req_c.misal & !kill_c;
    drain_c    = exc_c | (req_c & m_ready_i);
    drain0_c   = drain_c & !sel_c;
    drain1_c   = drain_c & sel_c;
    ready0_c   = !kill_c & (!full0_q | drain0_c);
    ready1_c   = !kill_c & (!full1_q | drain1_c);
    load0_c    = a0_valid_i & ready0_c;
    load1_c    = a1_valid_i & ready1_c;
    rem0_c     = full0_q & !drain0_c;
    rem1_c     = full1_q & !drain1_c;

    full0_d = rem0_c | load0_c;
    full1_d = rem1_c | load1_c;
    // A surviving slot is older than anything loaded alongside it.
    older_d = (rem0_c & rem1_c) ? older_q : (rem1_c & !rem0_c);
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (load0_c) slot0_d = '{a0_store_i, a0_misal_i, a0_addr_i, a0_data_i, a0_be_i, a0_rd_i};
    if (load1_c) slot1_d = '{a1_store_i, a1_misal_i, a1_addr_i, a1_data_i, a1_be_i, a1_rd_i};
    if (kill_c) begin
      full0_d = 1'b0;
      full1_d = 1'b0;
      older_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      older_q <= 1'b0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      full0_q <= full0_d;
      full1_q <= full1_d;
      older_q <= older_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign a0_ready_o  = ready0_c;
  assign a1_ready_o  = ready1_c;
  assign m_req_o     = req_c;
  assign m_we_o      = sel_req_c.store;
  assign m_addr_o    = sel_req_c.addr;
  assign m_wdata_o   = sel_req_c.data;
  assign m_be_o      = sel_req_c.be;
  assign m_rd_o      = sel_req_c.rd;
  assign m_port_o    = sel_c;
  assign exc_valid_o = exc_c;
  assign exc_addr_o  = sel_req_c.addr;
  assign exc_store_o = sel_req_c.store;
  assign exc_port_o  = sel_c;

endmodule
